// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the neural accelerator and its host-side readout
// engine (nn_result_reader).
//   NN_ADDR_W     : default neuron-RAM address / word-count width
//   NN_DATA_W     : default neuron-RAM data width
//   nn_rd_state_t : readout FSM state encoding
// -----------------------------------------------------------------------------
package nn_pkg;

    localparam int NN_ADDR_W = 8;
    localparam int NN_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } nn_rd_state_t;

endpackage : nn_pkg

// File: rtl/nn_result_reader.sv
// -----------------------------------------------------------------------------
// nn_result_reader
// Host-side readout engine for the accelerator's external neuron-RAM read
// port. A rising edge on `finished` latches the result window
// (base address, word count). The engine then walks the read address across
// the window, one outstanding read at a time, and presents each word on a
// valid/ready stream with a last marker.
//
// Ports
//   clk                       in   system clock, rising edge
//   reset                     in   asynchronous active-low reset
//   finished                  in   accelerator done flag (level)
//   result_base_address       in   first result word address
//   result_word_count         in   number of result words (0 = nothing to read)
//   neuron_ram_read_data_ext  in   neuron-RAM read data, RD_LATENCY after address
//   neuron_ram_read_adr_ext   out  neuron-RAM read address (registered)
//   out_data                  out  result word (registered)
//   out_valid                 out  out_data valid
//   out_ready                 in   consumer accepts word
//   out_last                  out  marks the final word of a readout
//   busy                      out  readout in progress (state != IDLE)
//   done                      out  one-cycle pulse at the end of a readout
// -----------------------------------------------------------------------------
module nn_result_reader
    import nn_pkg::*;
#(
    parameter int ADDR_W     = NN_ADDR_W,
    parameter int DATA_W     = NN_DATA_W,
    parameter int RD_LATENCY = 1          // 0 (combinational read) .. 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              finished,
    input  logic [ADDR_W-1:0] result_base_address,
    input  logic [ADDR_W-1:0] result_word_count,
    input  logic [DATA_W-1:0] neuron_ram_read_data_ext,
    output logic [ADDR_W-1:0] neuron_ram_read_adr_ext,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    // Two bits cover every legal read latency (0..3).
    localparam logic [1:0] RD_LAT = 2'(RD_LATENCY);

    nn_rd_state_t      state_q, state_d;
    logic              finished_q;
    logic              trigger;

    logic [ADDR_W-1:0] adr_q,   adr_d;
    logic [ADDR_W-1:0] idx_q,   idx_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [1:0]        lat_q,   lat_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              valid_q, valid_d;
    logic              last_q,  last_d;

    // Only a 0->1 transition of the level flag starts a readout; holding the
    // flag high never retriggers.
    assign trigger = finished && !finished_q;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        idx_d   = idx_q;
        count_d = count_q;
        lat_d   = lat_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    count_d = result_word_count;
                    if (result_word_count == '0) begin
                        // Empty result window: no read, straight to the done pulse.
                        state_d = DONE;
                    end else begin
                        adr_d   = result_base_address;
                        idx_d   = '0;
                        lat_d   = '0;
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                // lat_q counts edges since the address changed; the word is
                // valid on the RAM port once it reaches the read latency.
                if (lat_q == RD_LAT) begin
                    data_d  = neuron_ram_read_data_ext;
                    valid_d = 1'b1;
                    last_d  = (idx_q == count_q - ADDR_W'(1));
                    state_d = PRESENT;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end

            PRESENT: begin
                // Word and address hold until the consumer takes the word.
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        last_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        adr_d   = adr_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
                        lat_d   = '0;
                        state_d = WAIT;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath / edge-detect registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            finished_q <= 1'b0;
            adr_q      <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            lat_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            finished_q <= finished;
            adr_q      <= adr_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            lat_q      <= lat_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
        end
    end

    assign neuron_ram_read_adr_ext = adr_q;
    assign out_data                = data_q;
    assign out_valid               = valid_q;
    assign out_last                = last_q;
    assign busy                    = (state_q != IDLE);
    assign done                    = (state_q == DONE);

endmodule : nn_result_reader

// File: tb/tb_nn_result_reader.sv
// -----------------------------------------------------------------------------
// tb_nn_result_reader
// Three readers (read latency 0, 1 and 3) share stimulus, each fed by its own
// neuron-RAM model backed by a common memory array. Expected streams are the
// memory words at (base + i) mod 256 for i < count.
// -----------------------------------------------------------------------------
module tb_nn_result_reader;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       finished;
    logic       out_ready;
    logic [7:0] base_in;
    logic [7:0] count_in;
    logic [7:0] mem [256];

    logic [7:0] adr   [NI];
    logic [7:0] odata [NI];
    logic       ovalid[NI];
    logic       olast [NI];
    logic       obusy [NI];
    logic       odone [NI];

    int n_assert = 0;
    int n_fail   = 0;

    // Per-instance observation records from the last observe() call.
    int         hs_t [NI][$];
    logic [7:0] hs_d [NI][$];
    logic [7:0] hs_a [NI][$];
    logic       hs_l [NI][$];
    int         dn_t [NI][$];
    int         vcnt [NI];
    int         adr_nz[NI];

    always #5 clk = ~clk;

    function automatic int lat_of(int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
            logic [7:0] rdata;
            if (LAT == 0) begin : g_comb
                assign rdata = mem[adr[g]];
            end else begin : g_pipe
                logic [7:0] pipe [LAT];
                always @(posedge clk) begin
                    pipe[0] <= mem[adr[g]];
                    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
                end
                assign rdata = pipe[LAT-1];
            end

            nn_result_reader #(
                .ADDR_W    (8),
                .DATA_W    (8),
                .RD_LATENCY(LAT)
            ) u_dut (
                .clk                     (clk),
                .reset                   (reset),
                .finished                (finished),
                .result_base_address     (base_in),
                .result_word_count       (count_in),
                .neuron_ram_read_data_ext(rdata),
                .neuron_ram_read_adr_ext (adr[g]),
                .out_data                (odata[g]),
                .out_valid               (ovalid[g]),
                .out_ready               (out_ready),
                .out_last                (olast[g]),
                .busy                    (obusy[g]),
                .done                    (odone[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drop finished for one cycle, then raise it: the next edge triggers.
    task automatic pulse_trigger();
        @(negedge clk) finished = 1'b0;
        @(negedge clk) finished = 1'b1;
    endtask

    // Sample all readers at the falling edge for ncyc cycles. out_ready is held
    // low for stall_n cycles while reader 1 presents word stall_idx.
    task automatic observe(input int ncyc, input int stall_idx, input int stall_n,
                           input bit scramble, input logic [7:0] base);
        int  left;
        logic r;
        left = stall_n;
        for (int k = 0; k < NI; k++) begin
            hs_t[k].delete(); hs_d[k].delete(); hs_a[k].delete();
            hs_l[k].delete(); dn_t[k].delete();
            vcnt[k] = 0; adr_nz[k] = 0;
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            r = 1'b1;
            if (ovalid[1] && hs_d[1].size() == stall_idx && left > 0) begin
                r = 1'b0;
                left--;
                chk("stall_data", 32'(odata[1]), 32'(mem[(int'(base) + stall_idx) % 256]));
                chk("stall_adr",  32'(adr[1]),   32'((int'(base) + stall_idx) % 256));
            end
            out_ready = r;
            for (int k = 0; k < NI; k++) begin
                if (ovalid[k]) vcnt[k]++;
                if (adr[k] != 8'd0) adr_nz[k]++;
                if (odone[k]) dn_t[k].push_back(c);
                if (ovalid[k] && r) begin
                    hs_t[k].push_back(c);
                    hs_d[k].push_back(odata[k]);
                    hs_a[k].push_back(adr[k]);
                    hs_l[k].push_back(olast[k]);
                end
            end
            if (scramble) begin
                base_in  = 8'($urandom);
                count_in = 8'($urandom);
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic check_stream(input int k, input logic [7:0] base, input int cnt,
                                input bit spacing);
        int n;
        chk($sformatf("n_hs[%0d]", k), 32'(hs_d[k].size()), 32'(cnt));
        n = (hs_d[k].size() < cnt) ? hs_d[k].size() : cnt;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("data[%0d][%0d]", k, i), 32'(hs_d[k][i]), 32'(mem[(int'(base) + i) % 256]));
            chk($sformatf("adr[%0d][%0d]", k, i),  32'(hs_a[k][i]), 32'((int'(base) + i) % 256));
            chk($sformatf("last[%0d][%0d]", k, i), 32'(hs_l[k][i]), 32'(i == cnt - 1));
            if (spacing && i > 0)
                chk($sformatf("spacing[%0d][%0d]", k, i), 32'(hs_t[k][i] - hs_t[k][i-1]),
                    32'(lat_of(k) + 2));
        end
        chk($sformatf("n_done[%0d]", k), 32'(dn_t[k].size()), 32'd1);
        if (dn_t[k].size() > 0 && n > 0)
            chk($sformatf("done_t[%0d]", k), 32'(dn_t[k][0]), 32'(hs_t[k][n-1] + 1));
        chk($sformatf("busy_end[%0d]", k), 32'(obusy[k]), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s_adr[%0d]", tag, k),   32'(adr[k]),    32'd0);
            chk($sformatf("%s_data[%0d]", tag, k),  32'(odata[k]),  32'd0);
            chk($sformatf("%s_valid[%0d]", tag, k), 32'(ovalid[k]), 32'd0);
            chk($sformatf("%s_last[%0d]", tag, k),  32'(olast[k]),  32'd0);
            chk($sformatf("%s_busy[%0d]", tag, k),  32'(obusy[k]),  32'd0);
            chk($sformatf("%s_done[%0d]", tag, k),  32'(odone[k]),  32'd0);
        end
    endtask

    initial begin
        logic [7:0] b;
        int         cnt;
        int         h;
        bit         hit;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        reset     = 1'b1;
        finished  = 1'b0;
        out_ready = 1'b1;
        base_in   = 8'd0;
        count_in  = 8'd0;

        // Reset state
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // Zero count: no stream, done on the cycle after the trigger edge
        base_in  = 8'($urandom);
        count_in = 8'd0;
        pulse_trigger();
        observe(20, 0, 0, 1'b0, base_in);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("zero_valid[%0d]", k), 32'(vcnt[k]), 32'd0);
            chk($sformatf("zero_ndone[%0d]", k), 32'(dn_t[k].size()), 32'd1);
            if (dn_t[k].size() > 0)
                chk($sformatf("zero_done_t[%0d]", k), 32'(dn_t[k][0]), 32'd0);
            chk($sformatf("zero_adr[%0d]", k), 32'(adr_nz[k]), 32'd0);
        end

        // Basic readout
        mem[20] = 8'hA0; mem[21] = 8'hA1; mem[22] = 8'hA2;
        base_in = 8'd20; count_in = 8'd3;
        pulse_trigger();
        observe(40, 0, 0, 1'b0, 8'd20);
        for (int k = 0; k < NI; k++) check_stream(k, 8'd20, 3, 1'b1);

        // finished held high: no retrigger
        observe(50, 0, 0, 1'b0, 8'd20);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("hold_valid[%0d]", k), 32'(vcnt[k]), 32'd0);
            chk($sformatf("hold_done[%0d]", k),  32'(dn_t[k].size()), 32'd0);
        end

        // finished low for one cycle re-arms
        pulse_trigger();
        observe(40, 0, 0, 1'b0, 8'd20);
        for (int k = 0; k < NI; k++) check_stream(k, 8'd20, 3, 1'b1);

        // Backpressure on word A1 for 5 cycles
        pulse_trigger();
        observe(50, 1, 5, 1'b0, 8'd20);
        for (int k = 0; k < NI; k++) check_stream(k, 8'd20, 3, 1'b0);

        // Address wrap
        mem[254] = 8'h11; mem[255] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;
        base_in = 8'd254; count_in = 8'd4;
        pulse_trigger();
        observe(50, 0, 0, 1'b0, 8'd254);
        for (int k = 0; k < NI; k++) check_stream(k, 8'd254, 4, 1'b1);

        // Random windows, random stall, inputs scrambled after latching
        for (int t = 0; t < 4; t++) begin
            b   = 8'($urandom);
            cnt = $urandom_range(1, 5);
            for (int i = 0; i < cnt; i++) mem[(int'(b) + i) % 256] = 8'($urandom);
            base_in  = b;
            count_in = 8'(cnt);
            h = $urandom_range(0, 4);
            pulse_trigger();
            observe(60, $urandom_range(0, cnt - 1), h, 1'b1, b);
            for (int k = 0; k < NI; k++) check_stream(k, b, cnt, h == 0);
        end

        // Reset while reader 1 presents word 2
        base_in = 8'd20; count_in = 8'd3;
        pulse_trigger();
        out_ready = 1'b1;
        h   = 0;
        hit = 1'b0;
        for (int c = 0; c < 60 && !hit; c++) begin
            @(negedge clk);
            if (ovalid[1] && h == 2) hit = 1'b1;
            else if (ovalid[1]) h++;
        end
        chk("reach_word2", 32'(hit), 32'd1);
        #1 reset = 1'b0;
        #1 check_all_zero("midreset");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++)
                chk($sformatf("midreset_nodone[%0d]", k), 32'(odone[k]), 32'd0);
        end
        // Release with finished still high: fresh readout on the first edge
        reset = 1'b1;
        @(posedge clk);
        #1 chk("restart_busy", 32'(obusy[1]), 32'd1);
        observe(40, 0, 0, 1'b0, 8'd20);
        for (int k = 0; k < NI; k++) check_stream(k, 8'd20, 3, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_nn_result_reader
